// File: rtl/sub_64bit_serial_pkg.sv
// rtl/sub_64bit_serial_pkg.sv - shared state encodings and default sizes for the serial subtractor
package sub_64bit_serial_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_DIGIT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nsteps(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/sub_digit_4bit.sv
// rtl/sub_digit_4bit.sv - combinational digit slice of a + b_inv + cin with carry into the top bit
module sub_digit_4bit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b_inv,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0]   sum;
  logic [DIGIT-1:0] low;

  assign sum = {1'b0, a} + {1'b0, b_inv} + {{DIGIT{1'b0}}, cin};
  // Adding only the lower bits exposes the carry that enters the slice's top bit
  assign low = {1'b0, a[DIGIT-2:0]} + {1'b0, b_inv[DIGIT-2:0]} + {{(DIGIT-1){1'b0}}, cin};

  assign s     = sum[DIGIT-1:0];
  assign cout  = sum[DIGIT];
  assign c_msb = low[DIGIT-1];

endmodule

// File: rtl/sub_64bit_serial.sv
// rtl/sub_64bit_serial.sv - digit-serial A - B with Cout/OF/ZF/SF; ZF/SF built only with SUB_FLAGS_EN
module sub_64bit_serial
  import sub_64bit_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Cout,
  output logic             OF,
  output logic             ZF,
  output logic             SF
);

  localparam int NSTEPS = nsteps(WIDTH, DIGIT);
  localparam int SW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam logic [SW-1:0] LAST = SW'(NSTEPS - 1);

  state_e           state, state_nx;
  logic [WIDTH-1:0] a_q, binv_q, d_nx;
  logic [SW-1:0]    step;
  logic             carry;
  logic [DIGIT-1:0] dig_s;
  logic             dig_cout, dig_cmsb;
  logic             last_step;

  // Operand registers shift right each step, so the slice always sees bit 0 upward
  sub_digit_4bit #(.DIGIT(DIGIT)) u_digit (
    .a     (a_q[DIGIT-1:0]),
    .b_inv (binv_q[DIGIT-1:0]),
    .cin   (carry),
    .s     (dig_s),
    .cout  (dig_cout),
    .c_msb (dig_cmsb)
  );

  assign last_step = (step == LAST);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last_step) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    d_nx = D;
    d_nx[step*DIGIT +: DIGIT] = dig_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      binv_q <= '0;
      step   <= '0;
      carry  <= 1'b0;
      D      <= '0;
      Cout   <= 1'b0;
      OF     <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        a_q    <= A;
        binv_q <= ~B;
        carry  <= 1'b1;
        step   <= '0;
      end else if (state == RUN) begin
        a_q    <= a_q >> DIGIT;
        binv_q <= binv_q >> DIGIT;
        carry  <= dig_cout;
        step   <= step + 1'b1;
        D      <= d_nx;
        if (last_step) begin
          Cout <= dig_cout;
          OF   <= dig_cmsb ^ dig_cout;
        end
      end
    end
  end

`ifdef SUB_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ZF <= 1'b0;
      SF <= 1'b0;
    end else if (state == RUN && last_step) begin
      ZF <= (d_nx == '0);
      SF <= d_nx[WIDTH-1];
    end
  end
`else
  assign ZF = 1'b0;
  assign SF = 1'b0;
`endif

endmodule

// File: tb/tb_sub_64bit_serial.sv
// tb/tb_sub_64bit_serial.sv - directed vector bench for sub_64bit_serial
module tb_sub_64bit_serial;

`ifdef SUB_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] A = '0;
  logic [63:0] B = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] D;
  logic        Cout, OF, ZF, SF;

  int nchecks = 0;
  int nerrors = 0;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] d;
    logic        cout;
    logic        of;
    logic        zf;
    logic        sf;
  } vec_t;

  vec_t vecs[9];

  sub_64bit_serial dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .D(D), .Cout(Cout), .OF(OF), .ZF(ZF), .SF(SF)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [63:0] a, input logic [63:0] b);
    int i;
    for (i = 0; i < 40 && !in_ready; i++) @(negedge clk);
    chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    A = a;
    B = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = $urandom();
    B = $urandom();
  endtask

  task automatic wait_done(input string name);
    int cnt;
    cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      cnt = i;
      if (out_valid) break;
    end
    chk({name, "_latency"}, 64'(cnt), 64'd16);
  endtask

  task automatic check_result(input string name, input vec_t v);
    chk({name, "_D"},    D, v.d);
    chk({name, "_Cout"}, {63'd0, Cout}, {63'd0, v.cout});
    chk({name, "_OF"},   {63'd0, OF},   {63'd0, v.of});
    chk({name, "_ZF"},   {63'd0, ZF},   {63'd0, FLAGS ? v.zf : 1'b0});
    chk({name, "_SF"},   {63'd0, SF},   {63'd0, FLAGS ? v.sf : 1'b0});
  endtask

  task automatic finish_op(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({name, "_out_valid_drop"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{a: 64'd5, b: 64'd3, d: 64'd2, cout: 1, of: 0, zf: 0, sf: 0};
    vecs[1] = '{a: 64'h1234, b: 64'h1234, d: 64'd0, cout: 1, of: 0, zf: 1, sf: 0};
    vecs[2] = '{a: 64'd0, b: 64'd1, d: 64'hFFFF_FFFF_FFFF_FFFF, cout: 0, of: 0, zf: 0, sf: 1};
    vecs[3] = '{a: 64'h8000_0000_0000_0000, b: 64'd1, d: 64'h7FFF_FFFF_FFFF_FFFF, cout: 1, of: 1, zf: 0, sf: 0};
    vecs[4] = '{a: 64'h7FFF_FFFF_FFFF_FFFF, b: 64'hFFFF_FFFF_FFFF_FFFF, d: 64'h8000_0000_0000_0000, cout: 0, of: 1, zf: 0, sf: 1};
    vecs[5] = '{a: 64'd100, b: 64'd58, d: 64'd42, cout: 1, of: 0, zf: 0, sf: 0};
    vecs[6] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'hFFFF_FFFF_FFFF_FFFF, d: 64'd0, cout: 1, of: 0, zf: 1, sf: 0};
    vecs[7] = '{a: 64'h100, b: 64'd1, d: 64'hFF, cout: 1, of: 0, zf: 0, sf: 0};
    vecs[8] = '{a: 64'd1, b: 64'd2, d: 64'hFFFF_FFFF_FFFF_FFFF, cout: 0, of: 0, zf: 0, sf: 1};

    repeat (2) @(negedge clk);
    chk("reset_in_ready",  {63'd0, in_ready},  64'd1);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_D",         D, 64'd0);
    chk("reset_flags",     {60'd0, Cout, OF, ZF, SF}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_done($sformatf("vec%0d", i));
      check_result($sformatf("vec%0d", i), vecs[i]);
      finish_op($sformatf("vec%0d", i));
    end

    // Back-pressure in DONE with a competing request on the input
    start_op(vecs[3].a, vecs[3].b);
    wait_done("hold");
    A = 64'd5;
    B = 64'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
      chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
      check_result("hold", vecs[3]);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("hold_release_in_ready", {63'd0, in_ready}, 64'd1);
    chk("hold_release_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_done("hold_next");
    check_result("hold_next", vecs[0]);
    finish_op("hold_next");

    // Asynchronous reset in the middle of RUN
    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    repeat (8) @(posedge clk);
    #3;
    chk("pre_reset_D_partial", {63'd0, (D != 64'd0)}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_D", D, 64'd0);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_flags", {60'd0, Cout, OF, ZF, SF}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) break;
    end
    chk("postrst_no_result", {63'd0, out_valid}, 64'd0);
    v = vecs[5];
    start_op(v.a, v.b);
    wait_done("postrst");
    check_result("postrst", v);
    finish_op("postrst");

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
